dec_op_seq: RTL and testbench

Parametrised, sequential operation unit. A 2-bit opcode is decoded into a one-hot select driving one of four arithmetic/logic operations on two WIDTH-bit operands. Results are registered and returned through a start/busy/done handshake. It replaces the purely combinational 2-to-4 decode + four-operation block, adding generic operand width, operand latching, a multi-cycle multiplier and a completion handshake, so it can sit behind a sequencer or register interface.

---
 rtl/dec_op_seq.sv | 151 +++++++++++++++
 tb/tb_dec_op_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_op_seq.sv
// dec_op_seq: opcode-decoded ADD/SUB/MUL/AND unit with a start/busy/done
// handshake. ADD, SUB and AND finish in one EXEC cycle; MUL is an unsigned
// shift-add taking WIDTH EXEC cycles. All outputs are registered.
module dec_op_seq #(
    parameter int WIDTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               ENABLE,
    input  logic               START,
    input  logic [1:0]         DEC,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               BUSY,
    output logic               DONE,
    output logic [3:0]         OPSEL,
    output logic [2*WIDTH-1:0] RES
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_AND = 2'd3
    } op_t;

    // Registered state. opa is kept 2*WIDTH wide so that during MUL it can
    // serve as the left-shifting multiplicand; opb shifts right as the
    // multiplier. For single-cycle ops neither shifts before use.
    state_t        state, state_n;
    op_t           op, op_n;
    logic [RW-1:0] opa, opa_n;
    logic [WIDTH-1:0] opb, opb_n;
    logic [RW-1:0] acc, acc_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          busy, busy_n;
    logic          done, done_n;
    logic [3:0]    opsel, opsel_n;
    logic [RW-1:0] res, res_n;

    // Datapath results from the latched operands
    logic [RW-1:0]    ext_b;
    logic [RW-1:0]    add_res;
    logic [WIDTH:0]   sub_w;
    logic [RW-1:0]    sub_res;
    logic [RW-1:0]    and_res;
    logic [RW-1:0]    mul_step;

    // Operation results: SUB keeps the exact (WIDTH+1)-bit difference so the
    // sign bit is correct for any unsigned A, B before sign extension.
    always_comb begin
        ext_b    = {{WIDTH{1'b0}}, opb};
        add_res  = opa + ext_b;
        sub_w    = {1'b0, opa[WIDTH-1:0]} - {1'b0, opb};
        sub_res  = {{(WIDTH-1){sub_w[WIDTH]}}, sub_w};
        and_res  = opa & ext_b;
        mul_step = acc + (opb[0] ? opa : '0);
    end

    // State and output register; reset clears everything, aborting any op
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            op    <= OP_ADD;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            opsel <= 4'b0000;
            res   <= '0;
        end else begin
            state <= state_n;
            op    <= op_n;
            opa   <= opa_n;
            opb   <= opb_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            busy  <= busy_n;
            done  <= done_n;
            opsel <= opsel_n;
            res   <= res_n;
        end
    end

    // Next-state logic: accept in IDLE, step/complete in EXEC
    always_comb begin
        state_n = state;
        op_n    = op;
        opa_n   = opa;
        opb_n   = opb;
        acc_n   = acc;
        cnt_n   = cnt;
        busy_n  = busy;
        done_n  = 1'b0;
        opsel_n = opsel;
        res_n   = res;

        case (state)
            IDLE: begin
                if (START && ENABLE) begin
                    state_n = EXEC;
                    op_n    = op_t'(DEC);
                    opa_n   = {{WIDTH{1'b0}}, A};
                    opb_n   = B;
                    acc_n   = '0;
                    cnt_n   = (op_t'(DEC) == OP_MUL) ? CW'(WIDTH - 1) : '0;
                    busy_n  = 1'b1;
                    opsel_n = 4'b0001 << DEC;
                end
            end
            EXEC: begin
                if (op == OP_MUL) begin
                    acc_n = mul_step;
                    opa_n = opa << 1;
                    opb_n = opb >> 1;
                end
                if (cnt == '0) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    opsel_n = 4'b0000;
                    case (op)
                        OP_ADD:  res_n = add_res;
                        OP_SUB:  res_n = sub_res;
                        OP_MUL:  res_n = mul_step;
                        default: res_n = and_res;
                    endcase
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign BUSY  = busy;
    assign DONE  = done;
    assign OPSEL = opsel;
    assign RES   = res;

endmodule

// File: tb/tb_dec_op_seq.sv
// Bench for dec_op_seq: directed scenarios plus randomized operations with
// interference, checked against an arithmetic reference model.
module tb_dec_op_seq;

    logic       CLK = 1'b0;
    logic       RST, ENABLE, START, START8;
    logic [1:0] DEC;
    logic [3:0] A, B;
    logic [7:0] A8, B8;
    logic       BUSY, DONE, BUSY8, DONE8;
    logic [3:0] OPSEL, OPSEL8;
    logic [7:0] RES;
    logic [15:0] RES8;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    dec_op_seq #(.WIDTH(4)) dut4 (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .START(START), .DEC(DEC),
        .A(A), .B(B), .BUSY(BUSY), .DONE(DONE), .OPSEL(OPSEL), .RES(RES)
    );

    dec_op_seq #(.WIDTH(8)) dut8 (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .START(START8), .DEC(DEC),
        .A(A8), .B(B8), .BUSY(BUSY8), .DONE(DONE8), .OPSEL(OPSEL8), .RES(RES8)
    );

    // Reference: plain integer arithmetic reduced modulo 2^(2w)
    function automatic longint model(int w, int dec, longint a, longint b);
        longint mask = (longint'(1) << (2 * w)) - 1;
        case (dec)
            0:       return (a + b) & mask;
            1:       return (a - b) & mask;
            2:       return (a * b) & mask;
            default: return a & b;
        endcase
    endfunction

    function automatic int lat_model(int w, int dec);
        return (dec == 2) ? w : 1;
    endfunction

    // Drive one WIDTH=4 operation and gather observations. mode: 0 quiet,
    // 1 START+new operands during EXEC, 2 ENABLE low + START during EXEC,
    // 3 random interference.
    task automatic run4(input logic [1:0] dec, input logic [3:0] a, input logic [3:0] b,
                        input int mode, output int lat, output logic [7:0] res,
                        output logic [3:0] opsel0, output bit hs_ok,
                        output bit opsel_stable, output bit pulse_ok);
        int L;
        L = lat_model(4, dec);
        @(negedge CLK);
        DEC = dec; A = a; B = b; ENABLE = 1'b1; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        opsel0 = OPSEL;
        hs_ok = (BUSY === 1'b1) && (DONE === 1'b0);
        opsel_stable = 1'b1;
        lat = 0;
        while (DONE !== 1'b1 && lat < 64) begin
            if (BUSY !== 1'b1) hs_ok = 1'b0;
            if (OPSEL !== opsel0) opsel_stable = 1'b0;
            if (mode == 1) begin
                START = (lat + 1 < L); ENABLE = 1'b1;
                A = ~a; B = b + 4'd1; DEC = dec + 2'd1;
            end else if (mode == 2) begin
                START = (lat + 1 < L); ENABLE = 1'b0;
            end else if (mode == 3) begin
                START = (lat + 1 < L) ? 1'($urandom % 2) : 1'b0;
                ENABLE = 1'($urandom % 2);
                A = 4'($urandom); B = 4'($urandom); DEC = 2'($urandom);
            end
            @(posedge CLK); #1;
            lat++;
        end
        if (BUSY !== 1'b0 || OPSEL !== 4'b0000) hs_ok = 1'b0;
        res = RES;
        START = 1'b0; ENABLE = 1'b1;
        @(posedge CLK); #1;
        pulse_ok = (DONE === 1'b0) && (RES === res);
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b0; START8 = 1'b0; ENABLE = 1'b0;
        DEC = 2'd0; A = '0; B = '0; A8 = '0; B8 = '0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({BUSY, DONE, OPSEL, RES} !== 14'd0) begin
            errors++;
            $display("FAIL reset4 got busy=%b done=%b opsel=%b res=%h exp all 0", BUSY, DONE, OPSEL, RES);
        end
        checks++;
        if ({BUSY8, DONE8, OPSEL8, RES8} !== 22'd0) begin
            errors++;
            $display("FAIL reset8 got busy=%b done=%b opsel=%b res=%h exp all 0", BUSY8, DONE8, OPSEL8, RES8);
        end
        RST = 1'b0; ENABLE = 1'b1;
    endtask

    task automatic test_directed();
        int lat; logic [7:0] res; logic [3:0] os; bit hs, st, pl;
        // ADD with carry out
        run4(2'd0, 4'hF, 4'h1, 0, lat, res, os, hs, st, pl);
        checks++;
        if (lat != 1 || res !== 8'h10) begin
            errors++; $display("FAIL add got lat=%0d res=%h exp lat=1 res=10", lat, res);
        end
        checks++;
        if (os !== 4'b0001 || !hs || !st || !pl) begin
            errors++; $display("FAIL add_hs got opsel=%b hs=%0d st=%0d pulse=%0d exp 0001 1 1 1", os, hs, st, pl);
        end
        // SUB negative
        run4(2'd1, 4'h3, 4'h5, 0, lat, res, os, hs, st, pl);
        checks++;
        if (lat != 1 || res !== 8'hFE || os !== 4'b0010) begin
            errors++; $display("FAIL sub got lat=%0d res=%h opsel=%b exp 1 fe 0010", lat, res, os);
        end
        // AND
        run4(2'd3, 4'hC, 4'hA, 0, lat, res, os, hs, st, pl);
        checks++;
        if (lat != 1 || res !== 8'h08 || os !== 4'b1000) begin
            errors++; $display("FAIL and got lat=%0d res=%h opsel=%b exp 1 08 1000", lat, res, os);
        end
        // MUL full scale
        run4(2'd2, 4'hF, 4'hF, 0, lat, res, os, hs, st, pl);
        checks++;
        if (lat != 4 || res !== 8'hE1 || os !== 4'b0100 || !hs || !st || !pl) begin
            errors++; $display("FAIL mul4 got lat=%0d res=%h opsel=%b hs=%0d st=%0d pl=%0d exp 4 e1 0100 1 1 1",
                               lat, res, os, hs, st, pl);
        end
    endtask

    task automatic test_mul8();
        int lat;
        @(negedge CLK);
        DEC = 2'd2; A8 = 8'hFF; B8 = 8'hFF; START8 = 1'b1; ENABLE = 1'b1;
        @(posedge CLK); #1;
        START8 = 1'b0;
        lat = 0;
        while (DONE8 !== 1'b1 && lat < 64) begin
            @(posedge CLK); #1;
            lat++;
        end
        checks++;
        if (lat != 8 || longint'(RES8) != model(8, 2, 255, 255)) begin
            errors++; $display("FAIL mul8 got lat=%0d res=%h exp lat=8 res=fe01", lat, RES8);
        end
    endtask

    task automatic test_enable_gate();
        bit bad;
        bad = 1'b0;
        @(negedge CLK);
        ENABLE = 1'b0; START = 1'b1; DEC = 2'd0; A = 4'h2; B = 4'h3;
        repeat (6) begin
            @(posedge CLK); #1;
            if (BUSY !== 1'b0 || DONE !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL enable_gate got busy/done activity exp none");
        end
        START = 1'b0; ENABLE = 1'b1;
    endtask

    task automatic test_interference();
        int lat; logic [7:0] res; logic [3:0] os; bit hs, st, pl;
        run4(2'd2, 4'h7, 4'h9, 1, lat, res, os, hs, st, pl);
        checks++;
        if (lat != 4 || longint'(res) != model(4, 2, 7, 9) || !st || !pl) begin
            errors++; $display("FAIL start_during_mul got lat=%0d res=%h st=%0d pl=%0d exp lat=4 res=3f", lat, res, st, pl);
        end
        run4(2'd2, 4'hB, 4'hD, 2, lat, res, os, hs, st, pl);
        checks++;
        if (lat != 4 || longint'(res) != model(4, 2, 11, 13) || !hs) begin
            errors++; $display("FAIL enable_drop got lat=%0d res=%h hs=%0d exp lat=4 res=8f", lat, res, hs);
        end
    endtask

    task automatic test_reset_mid_mul();
        int dones;
        int lat; logic [7:0] res; logic [3:0] os; bit hs, st, pl;
        @(negedge CLK);
        DEC = 2'd2; A = 4'h7; B = 4'h5; START = 1'b1; ENABLE = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if ({BUSY, DONE, OPSEL, RES} !== 14'd0) begin
            errors++; $display("FAIL rst_mid_mul got busy=%b done=%b opsel=%b res=%h exp all 0", BUSY, DONE, OPSEL, RES);
        end
        RST = 1'b0;
        dones = 0;
        repeat (8) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1 || BUSY === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL rst_no_done got %0d active cycles exp 0", dones);
        end
        run4(2'd0, 4'h5, 4'h6, 0, lat, res, os, hs, st, pl);
        checks++;
        if (lat != 1 || res !== 8'h0B || !hs) begin
            errors++; $display("FAIL add_after_rst got lat=%0d res=%h exp 1 0b", lat, res);
        end
    endtask

    task automatic test_rst_start_same_edge();
        @(negedge CLK);
        RST = 1'b1; START = 1'b1; ENABLE = 1'b1; DEC = 2'd0; A = 4'h1; B = 4'h1;
        @(posedge CLK); #1;
        RST = 1'b0; START = 1'b0;
        checks++;
        if (BUSY !== 1'b0) begin
            errors++; $display("FAIL rst_start got busy=%b exp 0", BUSY);
        end
        @(posedge CLK); #1;
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++; $display("FAIL rst_start_after got busy=%b done=%b exp 0 0", BUSY, DONE);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        DEC = 2'd0; A = 4'h1; B = 4'h2; START = 1'b1; ENABLE = 1'b1;
        @(posedge CLK); #1;
        A = 4'h3; B = 4'h4;
        @(posedge CLK); #1;
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || RES !== 8'h03) begin
            errors++; $display("FAIL b2b_first got done=%b busy=%b res=%h exp 1 0 03", DONE, BUSY, RES);
        end
        @(posedge CLK); #1;
        START = 1'b0;
        checks++;
        if (BUSY !== 1'b1 || DONE !== 1'b0 || OPSEL !== 4'b0001) begin
            errors++; $display("FAIL b2b_reaccept got busy=%b done=%b opsel=%b exp 1 0 0001", BUSY, DONE, OPSEL);
        end
        @(posedge CLK); #1;
        checks++;
        if (DONE !== 1'b1 || RES !== 8'h07) begin
            errors++; $display("FAIL b2b_second got done=%b res=%h exp 1 07", DONE, RES);
        end
    endtask

    task automatic test_random();
        int lat; logic [7:0] res; logic [3:0] os; bit hs, st, pl;
        logic [1:0] d; logic [3:0] a, b;
        for (int i = 0; i < 40; i++) begin
            d = 2'($urandom_range(3));
            a = 4'($urandom); b = 4'($urandom);
            run4(d, a, b, int'($urandom_range(3)), lat, res, os, hs, st, pl);
            checks++;
            if (longint'(res) != model(4, d, a, b) || lat != lat_model(4, d)) begin
                errors++; $display("FAIL rand_res op=%0d a=%h b=%h got res=%h lat=%0d exp res=%h lat=%0d",
                                   d, a, b, res, lat, 8'(model(4, d, a, b)), lat_model(4, d));
            end
            checks++;
            if (os !== 4'(1 << d) || !hs || !st || !pl) begin
                errors++; $display("FAIL rand_hs op=%0d got opsel=%b hs=%0d st=%0d pl=%0d exp opsel=%b 1 1 1",
                                   d, os, hs, st, pl, 4'(1 << d));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul8();
        test_enable_gate();
        test_interference();
        test_reset_mid_mul();
        test_rst_start_same_edge();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule
